// File: rtl/cla_pkg.sv
// Shared carry-lookahead helpers: 4-bit group propagate/generate and the
// 4-way lookahead carry network reused at the second (group) level.
package cla_pkg;
  localparam int GRP_W   = 4;
  localparam int NUM_GRP = 4;

  // Returns {P, G} for a 4-bit group.
  function automatic logic [1:0] pg_group(input logic [GRP_W-1:0] p4,
                                          input logic [GRP_W-1:0] g4);
    logic pp, gg;
    pp = &p4;
    gg = g4[3] | (p4[3] & g4[2]) | (&p4[3:2] & g4[1]) | (&p4[3:1] & g4[0]);
    return {pp, gg};
  endfunction

  // Returns carries C[4:1] out of each of four positions given the carry-in.
  function automatic logic [4:1] lookahead4(input logic       cin,
                                            input logic [3:0] p,
                                            input logic [3:0] g);
    logic [4:1] c;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0])
         | (&p[3:0] & cin);
    return c;
  endfunction
endpackage

// File: rtl/cla16_pipe_adder_group4.sv
// 4-bit carry-lookahead group: sum bits from the group carry-in, plus group P/G.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] p,
  input  logic [GRP_W-1:0] g,
  input  logic             ci,
  output logic [GRP_W-1:0] s,
  output logic             Pg,
  output logic             Gg
);
  logic [GRP_W-1:0] c;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & ci);

  assign s        = p ^ c;
  assign {Pg, Gg} = pg_group(p, g);
endmodule

// File: rtl/cla16_pipe_adder.sv
// Two-stage pipelined 16-bit CLA adder with valid/ready on both sides.
// Stage 1 holds bit p/g; stage 2 resolves group carries and registers results.
module cla16_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             p_all,
  output logic             g_all,
  output logic [TAG_W-1:0] out_tag
);
  if (WIDTH != GRP_W * NUM_GRP) begin : g_width_chk
    $error("cla16_pipe_adder: only WIDTH = 16 is supported");
  end

  logic             s1_valid_q, s1_cin_q;
  logic [WIDTH-1:0] s1_p_q, s1_g_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             out_valid_q, cout_q, ovf_q, p_all_q, g_all_q;
  logic [WIDTH-1:0] sum_q;
  logic [TAG_W-1:0] tag_q;

  logic             in_xfer, s2_adv;
  logic [NUM_GRP-1:0] grp_p, grp_g;
  logic [NUM_GRP:0]   grp_c;
  logic [WIDTH-1:0]   sum_d;
  logic               cout_d, ovf_d, p_all_d, g_all_d;

  // in_ready sees out_ready combinationally so a full pipe can still stream.
  assign s2_adv   = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_adv;
  assign in_xfer  = in_valid & in_ready;

  assign grp_c[0]         = s1_cin_q;
  assign grp_c[NUM_GRP:1] = lookahead4(s1_cin_q, grp_p, grp_g);

  for (genvar k = 0; k < NUM_GRP; k++) begin : g_grp
    cla_group4 u_grp (
      .p  (s1_p_q[k*GRP_W +: GRP_W]),
      .g  (s1_g_q[k*GRP_W +: GRP_W]),
      .ci (grp_c[k]),
      .s  (sum_d[k*GRP_W +: GRP_W]),
      .Pg (grp_p[k]),
      .Gg (grp_g[k])
    );
  end

  assign {p_all_d, g_all_d} = pg_group(grp_p, grp_g);
  assign cout_d = grp_c[NUM_GRP];
  // Carry into the MSB is recovered as sum ^ p at that bit.
  assign ovf_d  = sum_d[WIDTH-1] ^ s1_p_q[WIDTH-1] ^ cout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_tag_q   <= '0;
    end else if (in_xfer) begin
      s1_valid_q <= 1'b1;
      s1_p_q     <= a ^ b;
      s1_g_q     <= a & b;
      s1_cin_q   <= cin;
      s1_tag_q   <= in_tag;
    end else if (s2_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      p_all_q     <= 1'b0;
      g_all_q     <= 1'b0;
      tag_q       <= '0;
    end else if (s2_adv) begin
      out_valid_q <= 1'b1;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      p_all_q     <= p_all_d;
      g_all_q     <= g_all_d;
      tag_q       <= s1_tag_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign p_all     = p_all_q;
  assign g_all     = g_all_q;
  assign out_tag   = tag_q;
endmodule

// File: tb/tb_cla16_pipe_adder.sv
// Bench for cla16_pipe_adder: directed corner cases plus randomized streams
// scored against an arithmetic reference model.
module tb_cla16_pipe_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic [3:0]  in_tag, out_tag;
  logic        cout, ovf, p_all, g_all;

  always #5 clk = ~clk;

  cla16_pipe_adder #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .p_all(p_all), .g_all(g_all), .out_tag(out_tag)
  );

  typedef struct packed {
    logic [3:0]  tag;
    logic [15:0] sum;
    logic        cout, ovf, pall, gall;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input logic [3:0] t);
    exp_t        e;
    logic [16:0] r, r0;
    r      = {1'b0, x} + {1'b0, y} + {16'b0, c};
    r0     = {1'b0, x} + {1'b0, y};
    e.tag  = t;
    e.sum  = r[15:0];
    e.cout = r[16];
    e.ovf  = (x[15] == y[15]) && (r[15] != x[15]);
    e.pall = ((x ^ y) == 16'hFFFF);
    e.gall = r0[16];
    return e;
  endfunction

  task automatic rand_op();
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_tag = 4'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0 ||
        p_all !== 1'b0 || g_all !== 1'b0 || out_tag !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: vld=%b sum=%h c=%b v=%b p=%b g=%b tag=%h, want all 0",
               out_valid, sum, cout, ovf, p_all, g_all, out_tag);
    end
    rst = 1'b0;
    @(negedge clk); in_valid = 1'b1; a = 16'h1234; b = 16'h4321; in_tag = 4'hA;
    @(posedge clk); #1 in_tag = 4'hB; a = 16'hFFFF;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fill: out_valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: vld=%b sum=%h tag=%h in_ready=%b, want 0/0000/0/1",
               out_valid, sum, out_tag, in_ready);
    end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_flush: out_valid=%b tag=%h after reset, want 0", out_valid, out_tag);
      end
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_tag = 4'h3; out_ready = 1'b1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: in_ready=%b, want 1", in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early: out_valid=%b one edge after accept, want 0", out_valid);
    end
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b1 || sum !== 16'h0100 || cout !== 1'b0 || ovf !== 1'b0 || out_tag !== 4'h3) begin
      n_fail++;
      $display("FAIL single_result: vld=%b sum=%h c=%b v=%b tag=%h, want 1/0100/0/0/3",
               out_valid, sum, cout, ovf, out_tag);
    end
  endtask

  task automatic test_ripple();
    @(negedge clk);
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000; cin = 1'b1; in_tag = 4'h5; out_ready = 1'b1;
    @(posedge clk); #1 a = 16'h7FFF; b = 16'h0001; cin = 1'b0; in_tag = 4'h6;
    @(posedge clk); #1 in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1 || p_all !== 1'b1 ||
        g_all !== 1'b0 || ovf !== 1'b0 || out_tag !== 4'h5) begin
      n_fail++;
      $display("FAIL ripple_ffff: vld=%b sum=%h c=%b p=%b g=%b v=%b tag=%h, want 1/0000/1/1/0/0/5",
               out_valid, sum, cout, p_all, g_all, ovf, out_tag);
    end
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b1 || sum !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1 || out_tag !== 4'h6) begin
      n_fail++;
      $display("FAIL ripple_ovf: vld=%b sum=%h c=%b v=%b tag=%h, want 1/8000/0/1/6",
               out_valid, sum, cout, ovf, out_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int          cyc = 0, acc_n = 0, got = 0;
    bit          acc, oxf, snap_ok = 0;
    logic [15:0] snap_sum = '0;
    logic [3:0]  snap_tag = '0;
    exp_t        e;
    sb.delete();
    out_ready = 1'b0; in_valid = 1'b1; rand_op(); in_tag = 4'h0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      oxf = out_valid && out_ready;
      if (cyc < 5 && acc_n >= 2) begin
        n_chk++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_full: in_ready=%b with both stages held, want 0", in_ready);
        end
        if (out_valid === 1'b1) begin
          if (!snap_ok) begin
            snap_ok = 1; snap_sum = sum; snap_tag = out_tag;
          end else begin
            n_chk++;
            if (sum !== snap_sum || out_tag !== snap_tag) begin
              n_fail++;
              $display("FAIL bp_stable: sum=%h tag=%h, want held %h/%h", sum, out_tag, snap_sum, snap_tag);
            end
          end
        end
      end
      if (oxf) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL bp_spurious: tag=%h with nothing outstanding, want none", out_tag);
        end else begin
          e = sb.pop_front();
          if (out_tag !== e.tag || sum !== e.sum || cout !== e.cout) begin
            n_fail++;
            $display("FAIL bp_order: tag=%h sum=%h c=%b, want %h/%h/%b", out_tag, sum, cout, e.tag, e.sum, e.cout);
          end
        end
        got++;
      end
      if (acc) begin
        sb.push_back(model(a, b, cin, in_tag));
        acc_n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (acc_n == 8) in_valid = 1'b0;
        else begin
          a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_tag = in_tag + 4'd1;
        end
      end
      out_ready = (cyc >= 5);
    end
    n_chk++;
    if (got != 8 || acc_n != 8 || !snap_ok) begin
      n_fail++; $display("FAIL bp_count: got=%0d accepted=%0d stall_seen=%0d, want 8/8/1", got, acc_n, snap_ok);
    end
  endtask

  task automatic test_throughput();
    int   sent = 0, got = 0;
    bit   acc;
    exp_t e;
    sb.delete();
    out_ready = 1'b1; in_valid = 1'b1; rand_op();
    for (int cyc = 0; cyc < 102; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      n_chk++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL tput_ready: cycle %0d in_ready=%b, want 1", cyc, in_ready);
      end
      if (cyc >= 2) begin
        n_chk++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL tput_bubble: cycle %0d out_valid=%b, want 1", cyc, out_valid);
        end
      end
      if (out_valid === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        got++;
        n_chk++;
        if (sum !== e.sum || cout !== e.cout || out_tag !== e.tag) begin
          n_fail++;
          $display("FAIL tput_data: sum=%h c=%b tag=%h, want %h/%b/%h", sum, cout, out_tag, e.sum, e.cout, e.tag);
        end
      end
      if (acc) begin sb.push_back(model(a, b, cin, in_tag)); sent++; end
      @(posedge clk); #1;
      if (sent == 100) in_valid = 1'b0; else rand_op();
    end
    n_chk++;
    if (got != 100) begin
      n_fail++; $display("FAIL tput_count: got=%0d results, want 100", got);
    end
  endtask

  task automatic test_random();
    int          sent = 0, got = 0, cyc = 0;
    bit          acc, oxf, stall = 0;
    logic [15:0] snap_sum = '0;
    logic [3:0]  snap_tag = '0;
    exp_t        e;
    sb.delete();
    in_valid = 1'b1; out_ready = 1'b1; rand_op();
    while (got < 10000 && cyc < 80000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      oxf = out_valid && out_ready;
      if (stall) begin
        n_chk++;
        if (out_valid !== 1'b1 || sum !== snap_sum || out_tag !== snap_tag) begin
          n_fail++;
          $display("FAIL rand_hold: vld=%b sum=%h tag=%h, want 1/%h/%h", out_valid, sum, out_tag, snap_sum, snap_tag);
        end
      end
      stall = out_valid && !out_ready;
      snap_sum = sum; snap_tag = out_tag;
      if (oxf) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious: tag=%h with nothing outstanding, want none", out_tag);
        end else begin
          e = sb.pop_front();
          if (out_tag !== e.tag || sum !== e.sum || cout !== e.cout || ovf !== e.ovf ||
              p_all !== e.pall || g_all !== e.gall) begin
            n_fail++;
            $display("FAIL rand_data: tag=%h sum=%h c=%b v=%b p=%b g=%b, want %h/%h/%b/%b/%b/%b",
                     out_tag, sum, cout, ovf, p_all, g_all, e.tag, e.sum, e.cout, e.ovf, e.pall, e.gall);
          end
        end
        got++;
      end
      if (acc) begin sb.push_back(model(a, b, cin, in_tag)); sent++; end
      @(posedge clk); #1;
      cyc++;
      in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      rand_op();
    end
    n_chk++;
    if (got != 10000 || sb.size() != 0) begin
      n_fail++; $display("FAIL rand_count: got=%0d left=%0d, want 10000/0", got, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ripple();
    test_backpressure();
    test_throughput();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
